// File: rtl/life_pkg.sv
// life_pkg: shared FSM encoding, Life rule constants and the per-cell rule
package life_pkg;
  typedef enum logic [1:0] {IDLE, CALC, WAIT_SWAP} state_t;
  localparam int BIRTH = 3;
  localparam int SURVIVE = 2;
  localparam int NCNT_W = 4;
  function automatic logic next_cell(input logic alive, input logic [NCNT_W-1:0] n);
    return (n == NCNT_W'(BIRTH)) | (alive & (n == NCNT_W'(SURVIVE)));
  endfunction
endpackage

// File: rtl/life_row_next.sv
// life_row_next: next-generation row from its upper, own and lower rows with column wrap
module life_row_next
  import life_pkg::*;
#(
  parameter int X = 8
) (
  input  logic [X-1:0] i_up,
  input  logic [X-1:0] i_mid,
  input  logic [X-1:0] i_dn,
  output logic [X-1:0] o_next
);
  for (genvar c = 0; c < X; c++) begin : g_col
    localparam int L = (c + X - 1) % X;
    localparam int R = (c + 1) % X;
    logic [NCNT_W-1:0] w_n;
    assign w_n = NCNT_W'(i_up[L]) + NCNT_W'(i_up[c]) + NCNT_W'(i_up[R]) +
                 NCNT_W'(i_mid[L]) + NCNT_W'(i_mid[R]) +
                 NCNT_W'(i_dn[L]) + NCNT_W'(i_dn[c]) + NCNT_W'(i_dn[R]);
    assign o_next[c] = next_cell(i_mid[c], w_n);
  end
endmodule

// File: rtl/life_grid.sv
// life_grid: toroidal Life board, row-serial generation into a shadow, frame-aligned swap
module life_grid
  import life_pkg::*;
#(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int FRAMES_PER_GEN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  input  logic                   load_en,
  input  logic [LOG2Y-1:0]       load_idx,
  input  logic [X-1:0]           load_row,
  output logic [LOG2X+LOG2Y-1:0] cnt,
  output logic [X-1:0]           top_row,
  output logic                   busy,
  output logic [15:0]            gen_count
);
  localparam logic [7:0] FLAST = 8'(FRAMES_PER_GEN - 1);
  localparam logic [LOG2X+LOG2Y-1:0] SWAP_AT = {LOG2Y'(Y - 2), {LOG2X{1'b1}}};
  logic [X-1:0] r_board [Y];
  logic [X-1:0] r_shadow [Y];
  logic [LOG2X+LOG2Y-1:0] r_cnt;
  logic [7:0] r_frame;
  logic [LOG2Y-1:0] r_row;
  logic [15:0] r_gen;
  state_t r_state;
  logic w_swap, w_auto;
  logic [LOG2Y-1:0] w_prev, w_succ, w_top;
  logic [X-1:0] w_next;
  assign w_swap = r_cnt == SWAP_AT;
  assign w_auto = w_swap & run & (r_frame == FLAST);
  assign w_prev = r_row - 1'b1;
  assign w_succ = r_row + 1'b1;
  assign w_top = r_cnt[LOG2X+LOG2Y-1:LOG2X] + 1'b1;
  assign cnt = r_cnt;
  assign top_row = r_board[w_top];
  assign busy = r_state != IDLE;
  assign gen_count = r_gen;
  life_row_next #(.X(X)) u_row (
    .i_up  (r_board[w_prev]),
    .i_mid (r_board[r_row]),
    .i_dn  (r_board[w_succ]),
    .o_next(w_next)
  );
  // scan counter and frame counter that paces automatic stepping
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= '0;
      r_frame <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_swap) r_frame <= (r_frame == FLAST) ? (run ? '0 : r_frame) : r_frame + 1'b1;
    end
  // board loading, row-serial generation and commit at the swap point; loads abort a generation
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < Y; i++) begin
        r_board[i] <= '0;
        r_shadow[i] <= '0;
      end
      r_state <= IDLE;
      r_row <= '0;
      r_gen <= '0;
    end else if (load_en) begin
      r_board[load_idx] <= load_row;
      r_state <= IDLE;
    end else if (r_state == IDLE) begin
      if (step | w_auto) begin
        r_state <= CALC;
        r_row <= '0;
      end
    end else if (r_state == CALC) begin
      r_shadow[r_row] <= w_next;
      r_row <= w_succ;
      if (r_row == LOG2Y'(Y - 1)) r_state <= WAIT_SWAP;
    end else if (w_swap) begin
      for (int i = 0; i < Y; i++) r_board[i] <= r_shadow[i];
      r_gen <= r_gen + 1'b1;
      r_state <= IDLE;
    end
endmodule

// File: tb/tb_life_grid.sv
// tb_life_grid: scoreboard bench for life_grid against a whole-board Life model
module tb_life_grid;
  typedef logic [7:0][7:0] board_t;
  typedef struct {board_t b; logic [15:0] g;} exp_t;
  logic clk = 0, rst = 1, run = 0, step = 0, load_en = 0;
  logic [2:0] load_idx = '0;
  logic [7:0] load_row = '0;
  logic [5:0] cnt;
  logic [7:0] top_row;
  logic busy;
  logic [15:0] gen_count;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  string tq[$];
  bit mon_active = 0;
  board_t mb;
  logic [15:0] mg;

  life_grid #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .FRAMES_PER_GEN(2)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .load_en(load_en),
    .load_idx(load_idx), .load_row(load_row), .cnt(cnt), .top_row(top_row),
    .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic board_t evolve(board_t b);
    board_t n;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        int c;
        c = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) c += int'(b[(y + dy + 8) % 8][(x + dx + 8) % 8]);
        n[y][x] = (c == 3) || (b[y][x] && c == 2);
      end
    return n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(board_t b, logic [15:0] g, string t);
    exp_t e;
    e.b = b;
    e.g = g;
    q.push_back(e);
    tq.push_back(t);
  endtask

  task automatic load_board(board_t b);
    for (int y = 0; y < 8; y++) begin
      load_en = 1;
      load_idx = 3'(y);
      load_row = b[y];
      tick();
    end
    load_en = 0;
    mb = b;
  endtask

  task automatic wait_cnt(logic [5:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (cnt !== c && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_cnt", cnt, c);
  endtask

  task automatic step_at(logic [5:0] c);
    wait_cnt(c);
    step = 1;
    tick();
    step = 0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((busy || q.size() != 0 || mon_active) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 400, 1);
  endtask

  task automatic wait_gen(output int at);
    int n;
    logic [15:0] g0;
    n = 0;
    g0 = gen_count;
    while (gen_count == g0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("gen_timeout", gen_count != g0, 1);
    at = cyc;
  endtask

  // monitor: whenever busy falls, the board and gen_count must match the oldest expectation
  initial begin
    exp_t e;
    string t;
    board_t b;
    logic pb;
    pb = 0;
    b = '0;
    forever begin
      @(negedge clk);
      if (pb && !busy) begin
        check("result_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          mon_active = 1;
          e = q.pop_front();
          t = tq.pop_front();
          check({t, "_gen"}, gen_count, e.g);
          for (int i = 0; i < 64; i++) begin
            if (cnt[2:0] == 3'd7) b[3'(cnt[5:3] + 1)] = top_row;
            if (i < 63) @(negedge clk);
          end
          check({t, "_board"}, b, e.b);
          mon_active = 0;
        end
      end
      pb = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    board_t r, n, z;
    logic [7:0] lr;
    int t1, t2, t3, mode, k, ri;
    repeat (2) tick();
    rst = 0;
    @(negedge clk);
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_gen", gen_count, 0);
    check("rst_top_row", top_row, 0);
    mb = '0;
    mg = 0;
    // reset in the middle of a generation
    r = {$urandom, $urandom};
    load_board(r);
    step_at(6'h05);
    tick();
    tick();
    push('0, 16'd0, "reset_mid_calc");
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("rst2_cnt", cnt, 0);
    check("rst2_busy", busy, 0);
    check("rst2_gen", gen_count, 0);
    check("rst2_top_row", top_row, 0);
    mb = '0;
    mg = 0;
    wait_idle();
    // blinker oscillates with period two
    z = '0;
    z[3] = 8'h1C;
    load_board(z);
    n = '0;
    n[2] = 8'h08;
    n[3] = 8'h08;
    n[4] = 8'h08;
    push(n, mg + 1, "blinker1");
    step_at(6'h00);
    k = 0;
    repeat (9) begin
      @(negedge clk);
      k += int'(busy);
    end
    check("blinker_busy", k, 9);
    mg++;
    wait_idle();
    push(z, mg + 1, "blinker2");
    step_at(6'h20);
    mg++;
    wait_idle();
    // block split across the wrap edges is a still life
    z = '0;
    z[0] = 8'h81;
    z[7] = 8'h81;
    load_board(z);
    push(z, mg + 1, "torus");
    step_at(6'h11);
    mg++;
    wait_idle();
    // frame coherence: old board up to the swap point, new board after it
    r = {$urandom, $urandom};
    load_board(r);
    n = evolve(r);
    push(n, mg + 1, "coherence");
    step_at(6'h10);
    wait_cnt(6'h37);
    check("coh_old_row7", top_row, r[7]);
    check("coh_busy_at_swap", busy, 1);
    wait_cnt(6'h3F);
    check("coh_new_row0", top_row, n[0]);
    mg++;
    wait_idle();
    // generation finishing on the swap point commits one frame later
    r = {$urandom, $urandom};
    load_board(r);
    push(evolve(r), mg + 1, "late_swap");
    step_at(6'h2F);
    wait_cnt(6'h38);
    check("late_swap_busy", busy, 1);
    check("late_swap_gen", gen_count, mg);
    mg++;
    wait_idle();
    // load and step together: load wins
    wait_cnt(6'h05);
    lr = 8'($urandom);
    step = 1;
    load_en = 1;
    load_idx = 3'd2;
    load_row = lr;
    tick();
    step = 0;
    load_en = 0;
    @(negedge clk);
    check("load_step_busy", busy, 0);
    wait_cnt(6'h0F);
    check("load_row_visible", top_row, lr);
    check("load_step_gen", gen_count, mg);
    wait_idle();
    // abort on the third calc cycle
    r = {$urandom, $urandom};
    load_board(r);
    lr = 8'($urandom);
    z = r;
    z[5] = lr;
    push(z, mg, "abort");
    step_at(6'h08);
    tick();
    tick();
    load_en = 1;
    load_idx = 3'd5;
    load_row = lr;
    tick();
    load_en = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    wait_cnt(6'h38);
    check("abort_no_swap_gen", gen_count, mg);
    wait_idle();
    // randomized generations, dropped steps and aborts
    for (int it = 0; it < 20; it++) begin
      r = {$urandom, $urandom};
      load_board(r);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        k = $urandom_range(1, 8);
        ri = $urandom_range(0, 7);
        lr = 8'($urandom);
        z = r;
        z[ri] = lr;
        push(z, mg, "rand_abort");
        step_at(6'($urandom_range(0, 63)));
        repeat (k - 1) tick();
        load_en = 1;
        load_idx = 3'(ri);
        load_row = lr;
        tick();
        load_en = 0;
      end else begin
        push(evolve(r), mg + 1, "rand_gen");
        step_at(6'($urandom_range(0, 63)));
        if (mode == 1) begin
          repeat ($urandom_range(0, 6)) tick();
          step = 1;
          tick();
          step = 0;
        end
        mg++;
      end
      wait_idle();
    end
    // automatic stepping every two frames, then stop
    z = '0;
    z[0] = 8'h81;
    z[7] = 8'h81;
    load_board(z);
    push(z, mg + 1, "auto1");
    push(z, mg + 2, "auto2");
    push(z, mg + 3, "auto3");
    run = 1;
    wait_gen(t1);
    wait_gen(t2);
    wait_gen(t3);
    run = 0;
    check("auto_period1", t2 - t1, 128);
    check("auto_period2", t3 - t2, 128);
    mg += 3;
    repeat (300) @(negedge clk);
    check("auto_stopped_gen", gen_count, mg);
    check("auto_stopped_busy", busy, 0);
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_grid.md
# life_grid

Holds the Game of Life board (B3/S23 rules, toroidal) and computes successive generations. Also drives the LED-matrix display stage that sits directly downstream of it.
- Supplies the free-running scan counter `cnt` and the next row to show, `top_row`.
- Computes each new generation row-serially into a shadow board.
- Swaps the shadow board in at a fixed frame point, so every displayed frame shows exactly one generation.

## Interface
Parameters:
- `X`, default 8: board width in cells; must equal 2^`LOG2X`.
- `Y`, default 8: board height in rows; must equal 2^`LOG2Y`.
- `LOG2X`, default 3: dwell bits (cycles per displayed row = 2^`LOG2X`).
- `LOG2Y`, default 3: row-index bits; `LOG2X` must equal `LOG2Y`.
- `FRAMES_PER_GEN`, default 16: frames per automatic generation step; valid range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: enables automatic stepping every `FRAMES_PER_GEN` frames.
- `step` in 1: single-cycle request for one generation.
- `load_en` in 1: writes `load_row` into current-board row `load_idx`.
- `load_idx` in `LOG2Y`: row to load.
- `load_row` in `X`: row data to load; bit i is column i.
- `cnt` out `LOG2X+LOG2Y`: scan counter; `cnt[LOG2X-1:0]` is the dwell count, the high bits are the row index.
- `top_row` out `X`: current-board row (row index + 1) mod Y; combinational from the board and `cnt`.
- `busy` out 1: high in CALC and WAIT_SWAP.
- `gen_count` out 16: number of generations committed.

## Operation
**Reset values:** board all 0, shadow board all 0, `cnt`=0, frame counter 0, state IDLE, `busy`=0, `gen_count`=0.

**Scan counter:** `cnt` increments every cycle and wraps from all-ones to 0. One frame is 2^(`LOG2X`+`LOG2Y`) cycles.

**Swap point:** the cycle where `cnt` = {Y-2, all-ones}, i.e. 55 (0x37) for 8×8.
- The display latches `top_row` when the dwell count is all-ones, so row 0 of a frame is sampled at `cnt`={Y-1, all-ones}.
- Committing at the swap point makes all Y samples of the next frame come from one board.

**Frame counter:**
- Increments at every swap point.
- When it reaches `FRAMES_PER_GEN`-1 at a swap point with `run`=1, it clears to 0 and raises an internal auto-request.
- With `run`=0 it saturates at `FRAMES_PER_GEN`-1.

**FSM:**
- IDLE → CALC on `step`=1 or auto-request. Row pointer r := 0.
- CALC, one row per cycle:
  - `shadow[r]` := next(board[r-1], board[r], board[r+1]), with row indices mod Y and columns wrapping mod X.
  - r increments each cycle; after r = Y-1 go to WAIT_SWAP.
  - CALC therefore lasts exactly Y cycles.
- WAIT_SWAP: at the swap point, board := shadow, `gen_count` += 1 (wraps at 16 bits), then go to IDLE.
- Cell rule: the neighbour count (0..8) is 4 bits wide.
  - Next state = (count==3) | (alive & count==2).

**Boundary conditions:**
- `step` or auto-request outside IDLE is dropped, not queued.
- `load_en`:
  - Writes the board at the next edge, in any state.
  - In CALC or WAIT_SWAP it also aborts to IDLE: the shadow board is discarded, there is no swap, and `gen_count` is unchanged.
  - `load_en` together with `step` in the same cycle: the load wins and the step is dropped.
- A swap point that arrives in the same cycle CALC finishes does not commit; the commit waits for the next frame's swap point.
- `rst` in any state restores all reset values at the next edge.

## Timing
- `step` sampled at edge t → `busy`=1 from t+1. CALC covers cycles t+1..t+Y; then WAIT_SWAP.
- The board update is visible on `top_row` in the cycle after the swap point.
- `load_en` at edge t → the new row is visible on `top_row` (when that row is indexed) from t+1.
- `busy` falls in the cycle after the swap or abort.
- `top_row` has zero latency from `cnt` and the board.

## Structure
- Package `life_pkg` holds:
  - FSM state enum: IDLE, CALC, WAIT_SWAP.
  - Rule constants: BIRTH=3, SURVIVE=2.
  - Neighbour-count width: 4.
- Sub-module `life_row_next` (combinational): takes three X-bit rows and returns the X-bit next row, with column wrap.
- The top level holds the board and shadow registers, `cnt`, the frame counter, and the FSM.

## Test plan
- **Reset:** assert `rst` mid-CALC → next cycle `cnt`=0, `busy`=0, `gen_count`=0, `top_row`=0x00.
- **Blinker:** load row 3 = 0x1C, pulse `step` → `busy`=1 for 8 CALC cycles plus WAIT_SWAP. At swap, rows 2,3,4 = 0x08 and row 3 ≠ 0x1C; `gen_count`=1. A second `step` restores row 3 = 0x1C.
- **Torus block:** load rows 0 and 7 = 0x81, pulse `step` → board unchanged after swap; `gen_count`=1.
- **Frame coherence:** mid-frame `step` → `top_row` at `cnt`=0x37 still shows the old row 7. From `cnt`=0x38 the new board shows: at `cnt`=0x3F, `top_row` = new row 0.
- **Auto-run:** `FRAMES_PER_GEN`=2, `run`=1 → `gen_count` increments every 128 cycles. `run`=0 → no further increments.
- **Abort:** `load_en` on the 3rd CALC cycle → `busy`=0 next cycle, `gen_count` unchanged, loaded row visible, no swap at the following swap point.
